// File: rtl/floor_gen_multi_pkg.sv
// Shared types, constants and helpers for the multi-channel floor generator.
// Provides the drop-speed decode and the LFSR rotation used for respawn heights.
package floor_pkg;

    typedef enum logic [0:0] {
        ST_ACTIVE = 1'b0,
        ST_WAIT   = 1'b1
    } floor_state_t;

    localparam int unsigned TG_BAND1 = 80;
    localparam int unsigned TG_BAND2 = 160;
    localparam int unsigned TG_BAND3 = 240;
    localparam int unsigned TG_BAND4 = 320;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Speed profile: the longer since the hit, the sparser the one-pixel steps.
    function automatic logic drop_step(input logic [8:0] time_gap, input logic hit_ceiling);
        logic s;
        s = 1'b0;
        if (!hit_ceiling || time_gap == 9'd0) begin
            s = 1'b0;
        end else if (time_gap < 9'(TG_BAND1)) begin
            s = 1'b1;
        end else if (time_gap < 9'(TG_BAND2)) begin
            s = (time_gap[0] == 1'b0);
        end else if (time_gap < 9'(TG_BAND3)) begin
            s = (time_gap[1:0] == 2'b00);
        end else if (time_gap < 9'(TG_BAND4)) begin
            s = (time_gap[2:0] == 3'b000);
        end
        return s;
    endfunction

    function automatic logic [7:0] rand_byte(input logic [15:0] v, input int unsigned k);
        logic [15:0] r;
        r = (v << k) | (v >> (16 - k));
        return r[7:0];
    endfunction

endpackage

// File: rtl/floor_gen_multi_if.sv
// Bus between game-state logic / renderer and the floor generator.
// The generator is the slave: it takes motion controls and returns floor positions.
interface floor_gen_multi_if #(
    parameter int N_FLOOR = 4,
    parameter int W       = 10
);
    logic                 frame_tick;
    logic                 hit_ceiling;
    logic [8:0]           time_gap;
    logic                 scroll_en;
    logic [N_FLOOR*W-1:0] floor_x;
    logic [N_FLOOR*W-1:0] floor_y;
    logic [N_FLOOR-1:0]   enable;
    logic [N_FLOOR-1:0]   respawn_pulse;

    modport master (
        output frame_tick, hit_ceiling, time_gap, scroll_en,
        input  floor_x, floor_y, enable, respawn_pulse
    );

    modport slave (
        input  frame_tick, hit_ceiling, time_gap, scroll_en,
        output floor_x, floor_y, enable, respawn_pulse
    );
endinterface

// File: rtl/floor_gen_multi_channel.sv
// One floor channel: drops/scrolls while active, retires off-field, then waits
// a fixed number of frame ticks and respawns at the right edge.
module floor_channel
    import floor_pkg::*;
#(
    parameter int W             = 10,
    parameter int X_RST         = 150,
    parameter int Y_RST         = 460,
    parameter int SCREEN_W      = 640,
    parameter int Y_MIN         = 120,
    parameter int Y_MAX         = 460,
    parameter int RESPAWN_DELAY = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         step,
    input  logic         scroll_en,
    input  logic [7:0]   rnd,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         enable,
    output logic         respawn_pulse
);

    localparam int CNT_W = $clog2(RESPAWN_DELAY + 1);
    localparam logic [W-1:0]     Y_MAX_W   = W'(Y_MAX);
    localparam logic [W-1:0]     X_EDGE_W  = W'(SCREEN_W - 1);
    localparam logic [W-1:0]     Y_MIN_W   = W'(Y_MIN);
    localparam logic [CNT_W-1:0] DELAY_CNT = CNT_W'(RESPAWN_DELAY);

    floor_state_t     state_reg, state_next;
    logic [W-1:0]     x_reg, x_next;
    logic [W-1:0]     y_reg, y_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             pulse_reg, pulse_next;

    logic [W:0]   y_sum;
    logic [W-1:0] y_drop;
    logic [W-1:0] x_scroll;
    logic         retire;

    // Saturating drop and floor-clamped scroll; retirement looks at the moved values.
    assign y_sum    = {1'b0, y_reg} + {{W{1'b0}}, step};
    assign y_drop   = y_sum[W] ? {W{1'b1}} : y_sum[W-1:0];
    assign x_scroll = (scroll_en && x_reg != '0) ? x_reg - 1'b1 : x_reg;
    assign retire   = (y_drop > Y_MAX_W) || (scroll_en && x_scroll == '0);

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        cnt_next   = cnt_reg;
        pulse_next = 1'b0;
        if (tick) begin
            unique case (state_reg)
                ST_ACTIVE: begin
                    x_next = x_scroll;
                    y_next = y_drop;
                    if (retire) begin
                        state_next = ST_WAIT;
                        cnt_next   = DELAY_CNT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == CNT_W'(1)) begin
                        state_next = ST_ACTIVE;
                        x_next     = X_EDGE_W;
                        y_next     = Y_MIN_W + W'(rnd);
                        cnt_next   = '0;
                        pulse_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                default: state_next = ST_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_ACTIVE;
            x_reg     <= W'(X_RST);
            y_reg     <= W'(Y_RST);
            cnt_reg   <= '0;
            pulse_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            cnt_reg   <= cnt_next;
            pulse_reg <= pulse_next;
        end
    end

    assign x             = x_reg;
    assign y             = y_reg;
    assign enable        = (state_reg == ST_ACTIVE);
    assign respawn_pulse = pulse_reg;

endmodule

// File: rtl/floor_gen_multi.sv
// N-channel floor generator: shared LFSR and drop decode feeding independent
// floor channels, with positions packed for the VGA renderer.
module floor_gen_multi
    import floor_pkg::*;
#(
    parameter int          N_FLOOR       = 4,
    parameter int          W             = 10,
    parameter int          X_START       = 150,
    parameter int          X_SPACING     = 150,
    parameter int          Y_TOP         = 460,
    parameter int          Y_STEP        = 85,
    parameter int          SCREEN_W      = 640,
    parameter int          Y_MIN         = 120,
    parameter int          Y_MAX         = 460,
    parameter int          RESPAWN_DELAY = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    floor_gen_multi_if.slave   bus
);

    logic [15:0] lfsr_reg;
    logic        step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_reg <= LFSR_SEED;
        end else if (bus.frame_tick) begin
            lfsr_reg <= {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
        end
    end

    assign step = drop_step(bus.time_gap, bus.hit_ceiling);

    generate
        for (genvar gi = 0; gi < N_FLOOR; gi++) begin : g_ch
            // Per-channel rotation keeps simultaneous respawns at different heights.
            logic [7:0]   rnd;
            logic [W-1:0] x;
            logic [W-1:0] y;

            assign rnd = rand_byte(lfsr_reg, (3 * gi) % 16);

            floor_channel #(
                .W             (W),
                .X_RST         (X_START + gi * X_SPACING),
                .Y_RST         (Y_TOP - gi * Y_STEP),
                .SCREEN_W      (SCREEN_W),
                .Y_MIN         (Y_MIN),
                .Y_MAX         (Y_MAX),
                .RESPAWN_DELAY (RESPAWN_DELAY)
            ) u_ch (
                .clk           (clk),
                .rst           (rst),
                .tick          (bus.frame_tick),
                .step          (step),
                .scroll_en     (bus.scroll_en),
                .rnd           (rnd),
                .x             (x),
                .y             (y),
                .enable        (bus.enable[gi]),
                .respawn_pulse (bus.respawn_pulse[gi])
            );

            assign bus.floor_x[gi*W +: W] = x;
            assign bus.floor_y[gi*W +: W] = y;
        end
    endgenerate

endmodule

// File: tb/tb_floor_gen_multi.sv
// Bench for floor_gen_multi: directed scenarios with literal expectations plus
// randomized ticks, all checked every cycle against an integer reference model.
module tb_floor_gen_multi;
    localparam int N = 4;
    localparam int W = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    floor_gen_multi_if #(.N_FLOOR(N), .W(W)) bus ();

    floor_gen_multi #(.N_FLOOR(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int nt     = 0;

    // ---------------- reference model ----------------
    int mx[N], my[N], mcnt[N];
    bit mact[N], mpulse[N];
    int mlfsr;
    bit mvalid = 1'b0;

    function automatic int lfsr_next(input int l);
        int fb;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return ((l << 1) | fb) & 16'hFFFF;
    endfunction

    function automatic int lfsr_after(input int n);
        int l;
        l = 16'hACE1;
        for (int k = 0; k < n; k++) l = lfsr_next(l);
        return l;
    endfunction

    function automatic int rotl(input int l, input int k);
        if (k == 0) return l;
        return ((l << k) | (l >> (16 - k))) & 16'hFFFF;
    endfunction

    function automatic int model_step(input bit h, input int g);
        if (!h || g == 0 || g >= 320) return 0;
        if (g < 80)  return 1;
        if (g < 160) return (g % 2 == 0) ? 1 : 0;
        if (g < 240) return (g % 4 == 0) ? 1 : 0;
        return (g % 8 == 0) ? 1 : 0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = 150 + i * 150;
            my[i] = 460 - i * 85;
            mact[i] = 1'b1;
            mcnt[i] = 0;
            mpulse[i] = 1'b0;
        end
        mlfsr = 16'hACE1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_reset();
            mvalid = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) mpulse[i] = 1'b0;
            if (bus.frame_tick) begin
                int st;
                st = model_step(bus.hit_ceiling, int'(bus.time_gap));
                for (int i = 0; i < N; i++) begin
                    if (mact[i]) begin
                        my[i] = (my[i] + st > 1023) ? 1023 : my[i] + st;
                        if (bus.scroll_en && mx[i] > 0) mx[i] = mx[i] - 1;
                        if (my[i] > 460 || (bus.scroll_en && mx[i] == 0)) begin
                            mact[i] = 1'b0;
                            mcnt[i] = 8;
                        end
                    end else if (mcnt[i] == 1) begin
                        mact[i] = 1'b1;
                        mx[i] = 639;
                        my[i] = 120 + (rotl(mlfsr, (3 * i) % 16) & 255);
                        mpulse[i] = 1'b1;
                        mcnt[i] = 0;
                    end else begin
                        mcnt[i] = mcnt[i] - 1;
                    end
                end
                mlfsr = lfsr_next(mlfsr);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (mvalid) begin
            logic [N*W-1:0] ex, ey;
            logic [N-1:0]   ee, ep;
            for (int i = 0; i < N; i++) begin
                ex[i*W +: W] = W'(mx[i]);
                ey[i*W +: W] = W'(my[i]);
                ee[i] = mact[i];
                ep[i] = mpulse[i];
            end
            n_cmp = n_cmp + 1;
            if (bus.floor_x !== ex || bus.floor_y !== ey || bus.enable !== ee || bus.respawn_pulse !== ep) begin
                n_fail = n_fail + 1;
                $display("FAIL model_cmp t=%0t x=%h/%h y=%h/%h en=%b/%b pulse=%b/%b (actual/required)",
                         $time, bus.floor_x, ex, bus.floor_y, ey, bus.enable, ee, bus.respawn_pulse, ep);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input bit t, input bit h, input int g, input bit s);
        bus.frame_tick  = t;
        bus.hit_ceiling = h;
        bus.time_gap    = 9'(g);
        bus.scroll_en   = s;
        @(posedge clk);
        #1;
        if (t) nt = nt + 1;
    endtask

    task automatic do_reset();
        bus.frame_tick = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        nt = 0;
        @(posedge clk); #1;
    endtask

    function automatic int fx(input int i); return int'(bus.floor_x[i*W +: W]); endfunction
    function automatic int fy(input int i); return int'(bus.floor_y[i*W +: W]); endfunction

    task automatic check_reset_vals(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_x%0d", tag, i), fx(i), 150 + 150 * i);
            check($sformatf("%s_y%0d", tag, i), fy(i), 460 - 85 * i);
        end
        check({tag, "_enable"}, int'(bus.enable), 15);
        check({tag, "_pulse"}, int'(bus.respawn_pulse), 0);
    endtask

    initial begin
        int l, ey0, ey1;
        bus.frame_tick = 1'b0; bus.hit_ceiling = 1'b0; bus.time_gap = '0; bus.scroll_en = 1'b0;

        // 1: reset values, stable without ticks
        do_reset();
        repeat (3) cyc(0, 1, 5, 1);
        check_reset_vals("rst");

        // 2: steady drop, channel 0 retires on first tick
        do_reset();
        repeat (3) cyc(1, 1, 5, 0);
        check("drop_y1", fy(1), 378);
        check("drop_y0_frozen", fy(0), 461);
        check("drop_y3", fy(3), 208);
        check("drop_enable", int'(bus.enable), 4'b1110);

        // 3: band decode
        do_reset();
        cyc(1, 1, 81, 0);  check("tg81_y1", fy(1), 375);
        cyc(1, 1, 82, 0);  check("tg82_y1", fy(1), 376);
        check("tg82_en0", int'(bus.enable[0]), 0);
        cyc(1, 1, 164, 0); check("tg164_y1", fy(1), 377);
        cyc(1, 1, 165, 0); check("tg165_y1", fy(1), 377);
        cyc(1, 1, 0, 0);   check("tg0_y1", fy(1), 377);
        cyc(1, 1, 320, 0); check("tg320_y1", fy(1), 377);

        // 4: scroll-out and respawn of channel 0
        do_reset();
        repeat (150) cyc(1, 0, 0, 1);
        check("scroll_x0", fx(0), 0);
        check("scroll_en0", int'(bus.enable[0]), 0);
        repeat (7) cyc(1, 0, 0, 1);
        check("wait_en0", int'(bus.enable[0]), 0);
        l = lfsr_after(nt);
        cyc(1, 0, 0, 1);
        check("resp_x0", fx(0), 639);
        check("resp_y0", fy(0), 120 + (l & 255));
        check("resp_pulse_hi", int'(bus.respawn_pulse), 1);
        cyc(0, 0, 0, 1);
        check("resp_pulse_lo", int'(bus.respawn_pulse), 0);

        // 5: align channels 0 and 1 at the right edge, then scroll both out together
        do_reset();
        cyc(1, 1, 1, 0);
        repeat (8) cyc(1, 0, 0, 0);
        repeat (85) cyc(1, 1, 1, 0);
        check("align_en1", int'(bus.enable[1]), 0);
        repeat (8) cyc(1, 0, 0, 0);
        check("align_x0", fx(0), 639);
        check("align_x1", fx(1), 639);
        repeat (639) cyc(1, 0, 0, 1);
        check("dual_retire", int'(bus.enable[1:0]), 0);
        repeat (7) cyc(1, 0, 0, 0);
        l = lfsr_after(nt);
        ey0 = 120 + (rotl(l, 0) & 255);
        ey1 = 120 + (rotl(l, 3) & 255);
        cyc(1, 0, 0, 0);
        check("dual_pulse", int'(bus.respawn_pulse[1:0]), 3);
        check("dual_y0", fy(0), ey0);
        check("dual_y1", fy(1), ey1);

        // 6: asynchronous reset while a channel is waiting
        do_reset();
        cyc(1, 1, 5, 0);
        cyc(1, 0, 0, 0);
        #2 rst = 1'b0;
        #1 check_reset_vals("async");
        @(posedge clk); #1;
        rst = 1'b1; nt = 0;
        @(posedge clk); #1;

        // randomized run against the model
        for (int k = 0; k < 4000; k++) begin
            int g;
            case ($urandom_range(0, 4))
                0: g = $urandom_range(1, 79);
                1: g = $urandom_range(80, 239);
                2: g = $urandom_range(240, 330);
                3: g = 0;
                default: g = $urandom_range(0, 511);
            endcase
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), g, ($urandom_range(0, 2) == 0));
        end
        cyc(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
